// File: rtl/psum_accum.sv
// Accumulates a programmed window of signed partial sums, rescales by an
// arithmetic right shift and hands one result downstream. Optional output saturation: PSUM_ACCUM_SAT_EN.
module psum_accum #(
    parameter int IWd   = 16,
    parameter int AccWd = 24,
    parameter int OWd   = 16,
    parameter int CntWd = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_start,
    input  logic [CntWd-1:0] i_acc_len,
    input  logic [3:0]       i_shift,
    input  logic [IWd-1:0]   i_sum,
    input  logic             sum_rdy,
    output logic             sum_ack,
    input  logic             sum_zero,
    output logic [OWd-1:0]   o_psum,
    output logic             psum_rdy,
    input  logic             psum_ack,
    output logic             psum_zero,
    output logic             o_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_HOLD
    } state_t;

    state_t                  r_state;
    logic signed [AccWd-1:0] r_acc;
    logic [CntWd-1:0]        r_cnt;
    logic [CntWd-1:0]        r_len;
    logic [3:0]              r_shift;
    logic                    r_zacc;
    logic [OWd-1:0]          r_psum;
    logic                    r_psum_rdy;
    logic                    r_psum_zero;

    logic                    w_hs;
    logic                    w_last;
    logic                    w_zacc_next;
    logic signed [AccWd-1:0] w_term;
    logic signed [AccWd-1:0] w_acc_next;
    logic signed [AccWd-1:0] w_shifted;
    logic [OWd-1:0]          w_res;

    assign w_hs        = sum_rdy && (r_state == S_ACC);
    assign w_last      = (r_cnt == r_len);
    assign w_zacc_next = r_zacc & sum_zero;
    assign w_term      = sum_zero ? '0 : {{(AccWd-IWd){i_sum[IWd-1]}}, i_sum};
    assign w_acc_next  = r_acc + w_term;
    assign w_shifted   = w_acc_next >>> r_shift;

`ifdef PSUM_ACCUM_SAT_EN
    // Out of range whenever the bits above the output sign bit disagree with the accumulator sign.
    logic w_ovf;
    assign w_ovf = (w_shifted[AccWd-1:OWd-1] != {(AccWd-OWd+1){w_shifted[AccWd-1]}});

    always_comb begin
        w_res = w_shifted[OWd-1:0];
        if (w_ovf) begin
            w_res = w_shifted[AccWd-1] ? {1'b1, {(OWd-1){1'b0}}} : {1'b0, {(OWd-1){1'b1}}};
        end
    end
`else
    logic w_unused_hi;
    assign w_res       = w_shifted[OWd-1:0];
    assign w_unused_hi = ^w_shifted[AccWd-1:OWd];
`endif

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_shift     <= '0;
            r_zacc      <= 1'b1;
            r_psum      <= '0;
            r_psum_rdy  <= 1'b0;
            r_psum_zero <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_len   <= i_acc_len;
                        r_shift <= i_shift;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_zacc  <= 1'b1;
                        r_state <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (w_hs) begin
                        r_acc  <= w_acc_next;
                        r_cnt  <= r_cnt + 1'b1;
                        r_zacc <= w_zacc_next;
                        if (w_last) begin
                            r_psum      <= w_res;
                            r_psum_zero <= w_zacc_next;
                            r_psum_rdy  <= 1'b1;
                            r_state     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (psum_ack) begin
                        r_psum_rdy <= 1'b0;
                        if (i_start) begin
                            r_len   <= i_acc_len;
                            r_shift <= i_shift;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_zacc  <= 1'b1;
                            r_state <= S_ACC;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sum_ack   = w_hs;
    assign o_psum    = r_psum;
    assign psum_rdy  = r_psum_rdy;
    assign psum_zero = r_psum_zero;
    assign o_busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_psum_accum.sv
// Directed plus randomized bench for psum_accum; reference sums windows with plain integer arithmetic.
module tb_psum_accum;

    logic        i_clk;
    logic        i_rstn;
    logic        i_start;
    logic [7:0]  i_acc_len;
    logic [3:0]  i_shift;
    logic [15:0] i_sum;
    logic        sum_rdy;
    logic        sum_ack;
    logic        sum_zero;
    logic [15:0] o_psum;
    logic        psum_rdy;
    logic        psum_ack;
    logic        psum_zero;
    logic        o_busy;

    int          n_total;
    int          n_pass;

    longint      m_total;
    bit          m_zall;
    int          m_sh;
    logic [15:0] m_last;

    psum_accum #(.IWd(16), .AccWd(24), .OWd(16), .CntWd(8)) dut (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_start   (i_start),
        .i_acc_len (i_acc_len),
        .i_shift   (i_shift),
        .i_sum     (i_sum),
        .sum_rdy   (sum_rdy),
        .sum_ack   (sum_ack),
        .sum_zero  (sum_zero),
        .o_psum    (o_psum),
        .psum_rdy  (psum_rdy),
        .psum_ack  (psum_ack),
        .psum_zero (psum_zero),
        .o_busy    (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Sum of non-zero terms, arithmetic shift, then wrap or clamp to 16 bits.
    function automatic logic [15:0] model_result(input longint total, input int sh);
        longint s;
        s = total >>> sh;
`ifdef PSUM_ACCUM_SAT_EN
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
`endif
        return s[15:0];
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic model_reset(input int sh);
        m_total = 0;
        m_zall  = 1'b1;
        m_sh    = sh;
    endtask

    task automatic start_win(input int len, input int sh);
        i_start   = 1'b1;
        i_acc_len = 8'(len);
        i_shift   = 4'(sh);
        model_reset(sh);
        tick();
        i_start = 1'b0;
        check1("busy_after_start", o_busy, 1'b1);
    endtask

    task automatic feed(input logic [15:0] v, input logic z);
        sum_rdy  = 1'b1;
        i_sum    = v;
        sum_zero = z;
        #1;
        check1("sum_ack_in_acc", sum_ack, 1'b1);
        check1("psum_rdy_before_last", psum_rdy, 1'b0);
        if (!z) m_total += longint'($signed(v));
        m_zall &= z;
        tick();
        sum_rdy  = 1'b0;
        sum_zero = 1'b0;
    endtask

    task automatic gap();
        sum_rdy = 1'b0;
        i_sum   = 16'($urandom);
        #1;
        check1("sum_ack_gap", sum_ack, 1'b0);
        tick();
    endtask

    task automatic check_result(input string tag);
        m_last = model_result(m_total, m_sh);
        check1({tag, "_rdy"}, psum_rdy, 1'b1);
        check16({tag, "_psum"}, o_psum, m_last);
        check1({tag, "_zero"}, psum_zero, m_zall);
        sum_rdy = 1'b1;
        #1;
        check1({tag, "_ack_hold"}, sum_ack, 1'b0);
        sum_rdy = 1'b0;
    endtask

    task automatic ack_out();
        psum_ack = 1'b1;
        tick();
        psum_ack = 1'b0;
        check1("rdy_after_ack", psum_rdy, 1'b0);
        check1("idle_after_ack", o_busy, 1'b0);
        check16("psum_retained", o_psum, m_last);
    endtask

    task automatic rand_window(input int len);
        int sh;
        sh = $urandom_range(0, 15);
        start_win(len, sh);
        for (int k = 0; k <= len; k++) begin
            if ($urandom_range(0, 3) == 0) gap();
            feed(16'($urandom), ($urandom_range(0, 3) == 0));
        end
        check_result("rand");
        repeat ($urandom_range(0, 2)) begin
            tick();
            check1("rand_hold_rdy", psum_rdy, 1'b1);
        end
        ack_out();
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        i_rstn    = 1'b0;
        i_start   = 1'b0;
        i_acc_len = '0;
        i_shift   = '0;
        i_sum     = '0;
        sum_rdy   = 1'b0;
        sum_zero  = 1'b0;
        psum_ack  = 1'b0;
        m_last    = '0;
        model_reset(0);

        tick();
        tick();
        sum_rdy = 1'b1;
        #1;
        check16("rst_psum", o_psum, 16'h0000);
        check1("rst_rdy", psum_rdy, 1'b0);
        check1("rst_zero", psum_zero, 1'b1);
        check1("rst_sum_ack", sum_ack, 1'b0);
        check1("rst_busy", o_busy, 1'b0);
        i_rstn = 1'b1;
        tick();
        #1;
        check1("idle_sum_ack", sum_ack, 1'b0);
        sum_rdy = 1'b0;
        tick();

        // Basic window, with a stray i_start mid-window that must be ignored.
        start_win(3, 0);
        feed(16'd5, 1'b0);
        i_start   = 1'b1;
        i_acc_len = 8'd0;
        feed(-16'sd2, 1'b0);
        i_start = 1'b0;
        feed(16'd7, 1'b0);
        feed(16'd1, 1'b0);
        check_result("basic");
        check16("basic_const", o_psum, 16'd11);
        ack_out();

        // Zero-flagged terms.
        start_win(2, 0);
        repeat (3) feed(16'h1234, 1'b1);
        check_result("zskip");
        check16("zskip_const", o_psum, 16'h0000);
        check1("zskip_zero_const", psum_zero, 1'b1);
        ack_out();

        // Gaps, stray psum_ack, long hold with a stray i_start.
        start_win(1, 2);
        feed(-16'sd9, 1'b0);
        psum_ack = 1'b1;
        gap();
        gap();
        psum_ack = 1'b0;
        feed(-16'sd3, 1'b0);
        check_result("bp");
        check16("bp_const", o_psum, 16'hFFFD);
        for (int c = 0; c < 5; c++) begin
            i_start   = (c == 2);
            i_acc_len = 8'd7;
            sum_rdy   = 1'b1;
            tick();
            check1("bp_hold_rdy", psum_rdy, 1'b1);
            check16("bp_hold_psum", o_psum, 16'hFFFD);
            check1("bp_hold_ack", sum_ack, 1'b0);
            check1("bp_hold_busy", o_busy, 1'b1);
        end
        i_start = 1'b0;
        sum_rdy = 1'b0;

        // Ack and start together: straight back into accumulation.
        psum_ack  = 1'b1;
        i_start   = 1'b1;
        i_acc_len = 8'd0;
        i_shift   = 4'd0;
        model_reset(0);
        tick();
        psum_ack = 1'b0;
        i_start  = 1'b0;
        check1("b2b_busy", o_busy, 1'b1);
        check1("b2b_rdy", psum_rdy, 1'b0);
        feed(16'd100, 1'b0);
        check_result("b2b");
        check16("b2b_const", o_psum, 16'd100);
        ack_out();

        // Overflow of the output range.
        start_win(3, 0);
        repeat (4) feed(16'h7FFF, 1'b0);
        check_result("ovf");
`ifdef PSUM_ACCUM_SAT_EN
        check16("ovf_const", o_psum, 16'h7FFF);
`else
        check16("ovf_const", o_psum, 16'hFFFC);
`endif
        ack_out();

        // Reset in the middle of a window.
        start_win(3, 0);
        feed(16'd20, 1'b0);
        feed(16'd30, 1'b0);
        sum_rdy = 1'b1;
        i_rstn  = 1'b0;
        #1;
        check16("mrst_psum", o_psum, 16'h0000);
        check1("mrst_rdy", psum_rdy, 1'b0);
        check1("mrst_zero", psum_zero, 1'b1);
        check1("mrst_sum_ack", sum_ack, 1'b0);
        check1("mrst_busy", o_busy, 1'b0);
        sum_rdy = 1'b0;
        tick();
        i_rstn = 1'b1;
        tick();
        start_win(0, 0);
        feed(16'd4, 1'b0);
        check_result("mrst_new");
        check16("mrst_new_const", o_psum, 16'd4);
        ack_out();

        // Randomized windows, including the maximum length.
        for (int w = 0; w < 20; w++) rand_window($urandom_range(0, 15));
        rand_window(255);
        rand_window(0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
